hand_render_scheduler: RTL and testbench
========================================

// Module: hand_render_scheduler
// PURPOSE
//  Owns the player's hand (up to MAX_CARDS card codes) and feeds the single Card renderer pixel by pixel.
//  Per pixel it picks the slot covering (x_cnt,y_cnt) and drives card/x_pin/y_pin to Card.
//  Hand edits arrive via a valid/ready command port and commit only at frame_start (no tearing).
//  A cursor marks the selected card; that card is drawn raised by RAISE pixels.
// PARAMETERS
//  MAX_CARDS  8    hand capacity (slots 0..MAX_CARDS-1)
//  CARD_W     60   card width, pixels
//  CARD_H     90   card height, pixels
//  HAND_X0    40   x of slot 0 left edge
//  HAND_Y0    380  y of unraised card top edge
//  SPACING    70   x pitch between slot left edges
//  RAISE      10   upward offset of the cursor slot
// PORTS
//  clk         in   1   pixel clock, single domain
//  rst_n       in   1   synchronous reset, active low
//  x_cnt       in   10  current pixel x from VGA timing
//  y_cnt       in   10  current pixel y
//  frame_start in   1   1-cycle pulse at start of vertical blank
//  cmd_valid   in   1   command request
//  cmd_ready   out  1   1 = no command pending
//  cmd_op      in   2   0 ADD, 1 REMOVE, 2 CLEAR, 3 reserved (treated as NOP)
//  cmd_card    in   6   card code for ADD
//  cmd_idx     in   3   slot index for REMOVE
//  cmd_done    out  1   1-cycle pulse: pending command committed
//  cmd_err     out  1   1-cycle pulse with cmd_done: command rejected
//  cur_left    in   1   pulse: cursor -1 (wraps)
//  cur_right   in   1   pulse: cursor +1 (wraps)
//  cursor      out  3   selected slot
//  hand_count  out  4   cards held, 0..MAX_CARDS
//  card        out  6   code to Card; NO_CARD when no hit
//  card_hit    out  1   1 = pixel lies on a card
//  x_pin       out  10  left edge of hit slot
//  y_pin       out  10  top edge of hit slot (raised if cursor)
//  x_cnt_d     out  10  x_cnt delayed 1 cycle (aligned to card)
//  y_cnt_d     out  10  y_cnt delayed 1 cycle
// BEHAVIOUR
//  Reset: slots=NO_CARD, hand_count=0, cursor=0, cmd_ready=1, cmd_done=cmd_err=0,
//   card=NO_CARD, card_hit=0, x_pin=y_pin=x_cnt_d=y_cnt_d=0, pending cleared. Reset mid-command drops it.
//  Command FSM: IDLE (ready=1) --valid--> PEND (ready=0, op/card/idx latched) --frame_start--> COMMIT -> IDLE.
//   Command accepted in same cycle as frame_start stays pending until the NEXT frame_start.
//   COMMIT is one cycle; cmd_done pulses the cycle after frame_start; ready=1 again that cycle.
//  ADD: slot[count]<=cmd_card, count+1; if count==MAX_CARDS -> err, hand unchanged.
//  REMOVE: slots idx+1..count-1 shift down one in the same cycle, slot[count-1]<=NO_CARD, count-1;
//   idx>=count -> err, hand unchanged.
//  CLEAR: all slots NO_CARD, count=0, cursor=0; never errs. Reserved op: done, no err, no change.
//  Cursor: after any commit, cursor=min(cursor,count-1), or 0 if count==0.
//   left at 0 -> count-1; right at count-1 -> 0. Moves ignored when count==0.
//   Move in the commit cycle is evaluated against the post-commit count/clamp. left&right together: no move.
//  Pixel path: slot i rect = x in [HAND_X0+i*SPACING, +CARD_W), y in [ys, ys+CARD_H),
//   ys = HAND_Y0-RAISE if i==cursor else HAND_Y0; only i<count qualify.
//   Highest hit index wins. Comparisons use 11-bit unsigned arithmetic, no wrap.
//  Outputs registered, latency exactly 1 cycle from x_cnt/y_cnt. On miss: card=NO_CARD, hit=0, pins hold 0.
//  Hand/cursor used by hit test are the registered state (commit visible from the next pixel).
// STRUCTURE
//  uno_pkg: typedef logic [5:0] card_t; localparam card_t NO_CARD=6'h3F;
//   typedef enum logic [1:0] {OP_ADD, OP_REMOVE, OP_CLEAR, OP_NOP} hand_op_e.
//  Sub-module hand_hit_test: combinational priority search over slots -> hit, idx, x_pin, y_pin.
//  Top: slot array, count, cursor, command FSM, output registers.
// TESTING
//  1 Reset, ADD 6'h05 then frame_start -> cmd_done next cycle, count=1; pixel (45,375) -> card=05, pins (40,370) 1 cycle later.
//  2 ADD 8 cards, 9th ADD + frame_start -> cmd_done & cmd_err, count stays 8.
//  3 Hand {01,02,03}, cursor=2, REMOVE idx 0 -> slots {02,03}, cursor=1; REMOVE idx 5 -> err.
//  4 cmd_valid in frame_start cycle -> no commit until next frame_start; cmd_ready=0 meanwhile.
//  5 count=3, cursor=0, cur_left -> cursor=2; cur_right -> 0; both pulses -> unchanged; count=0 -> ignored.
//  6 Pixel (45,372) with cursor=0 -> hit; cursor=1 -> miss (slot 0 y range 380..469), card=3F.

Source files
------------

// File: rtl/uno_pkg.sv
// Shared types and geometry for the hand renderer: card codes, hand ops, command FSM states.
package uno_pkg;

  typedef logic [5:0] card_t;
  localparam card_t NO_CARD = 6'h3F;

  typedef enum logic [1:0] {OP_ADD, OP_REMOVE, OP_CLEAR, OP_NOP} hand_op_e;
  typedef enum logic [1:0] {CMD_IDLE, CMD_PEND, CMD_COMMIT} cmd_state_e;

  localparam int unsigned MAX_CARDS = 8;
  localparam int unsigned CARD_W    = 60;
  localparam int unsigned CARD_H    = 90;
  localparam int unsigned HAND_X0   = 40;
  localparam int unsigned HAND_Y0   = 380;
  localparam int unsigned SPACING   = 70;
  localparam int unsigned RAISE     = 10;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned CMP_W   = 11;

endpackage

// File: rtl/hand_hit_test.sv
// Combinational search for the highest-index held slot covering the current pixel.
module hand_hit_test
  import uno_pkg::*;
(
  input  logic [9:0]                 x_cnt,
  input  logic [9:0]                 y_cnt,
  input  logic [3:0]                 count,
  input  logic [2:0]                 cursor,
  output logic                       hit_c,
  output logic [2:0]                 idx_c,
  output logic [9:0]                 x_pin_c,
  output logic [9:0]                 y_pin_c
);

  logic [CMP_W-1:0] x11, y11, xl, ys;

  assign x11 = {1'b0, x_cnt};
  assign y11 = {1'b0, y_cnt};

  // Ascending scan so a later (higher) slot overrides an earlier hit.
  always_comb begin
    hit_c   = 1'b0;
    idx_c   = 3'd0;
    x_pin_c = 10'd0;
    y_pin_c = 10'd0;
    xl      = '0;
    ys      = '0;
    for (int i = 0; i < MAX_CARDS; i++) begin
      xl = CMP_W'(HAND_X0 + i * SPACING);
      ys = (3'(i) == cursor) ? CMP_W'(HAND_Y0 - RAISE) : CMP_W'(HAND_Y0);
      if ((4'(i) < count) &&
          (x11 >= xl) && (x11 < xl + CMP_W'(CARD_W)) &&
          (y11 >= ys) && (y11 < ys + CMP_W'(CARD_H))) begin
        hit_c   = 1'b1;
        idx_c   = 3'(i);
        x_pin_c = COORD_W'(xl);
        y_pin_c = COORD_W'(ys);
      end
    end
  end

endmodule

// File: rtl/hand_render_scheduler.sv
// Holds the player's hand, commits edits at frame_start, and feeds the card renderer per pixel.
module hand_render_scheduler
  import uno_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] x_cnt,
  input  logic [9:0] y_cnt,
  input  logic       frame_start,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [5:0] cmd_card,
  input  logic [2:0] cmd_idx,
  output logic       cmd_done,
  output logic       cmd_err,
  input  logic       cur_left,
  input  logic       cur_right,
  output logic [2:0] cursor,
  output logic [3:0] hand_count,
  output logic [5:0] card,
  output logic       card_hit,
  output logic [9:0] x_pin,
  output logic [9:0] y_pin,
  output logic [9:0] x_cnt_d,
  output logic [9:0] y_cnt_d
);

  cmd_state_e state_q, state_d;
  hand_op_e   op_q, op_d;
  card_t      arg_card_q, arg_card_d;
  logic [2:0] arg_idx_q, arg_idx_d;

  card_t [MAX_CARDS-1:0] slots_q, slots_d, shifted;
  logic [3:0] count_q, count_d;
  logic [2:0] cursor_q, cursor_d;
  logic       ready_q, ready_d, done_q, done_d, err_q, err_d;
  logic       commit;

  logic       hit_c;
  logic [2:0] hit_idx_c;
  logic [9:0] x_pin_c, y_pin_c;

  assign cmd_ready  = ready_q;
  assign cmd_done   = done_q;
  assign cmd_err    = err_q;
  assign cursor     = cursor_q;
  assign hand_count = count_q;

  // Hand as it would look after removing slot 0; REMOVE picks entries from here above idx.
  always_comb begin
    shifted = slots_q;
    for (int i = 0; i < MAX_CARDS - 1; i++) begin
      shifted[i] = slots_q[i + 1];
    end
    shifted[MAX_CARDS-1] = NO_CARD;
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    arg_card_d = arg_card_q;
    arg_idx_d  = arg_idx_q;
    slots_d    = slots_q;
    count_d    = count_q;
    cursor_d   = cursor_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    commit     = 1'b0;

    case (state_q)
      CMD_IDLE, CMD_COMMIT: begin
        state_d = CMD_IDLE;
        if (cmd_valid) begin
          state_d    = CMD_PEND;
          op_d       = hand_op_e'(cmd_op);
          arg_card_d = cmd_card;
          arg_idx_d  = cmd_idx;
        end
      end
      CMD_PEND: begin
        if (frame_start) begin
          state_d = CMD_COMMIT;
          commit  = 1'b1;
        end
      end
      default: state_d = CMD_IDLE;
    endcase

    if (commit) begin
      done_d = 1'b1;
      case (op_q)
        OP_ADD: begin
          if (count_q == 4'(MAX_CARDS)) begin
            err_d = 1'b1;
          end else begin
            slots_d[count_q[2:0]] = arg_card_q;
            count_d               = count_q + 4'd1;
          end
        end
        OP_REMOVE: begin
          if ({1'b0, arg_idx_q} >= count_q) begin
            err_d = 1'b1;
          end else begin
            for (int i = 0; i < MAX_CARDS; i++) begin
              if ((4'(i) >= {1'b0, arg_idx_q}) && (4'(i) < count_q - 4'd1)) slots_d[i] = shifted[i];
              if (4'(i) == count_q - 4'd1) slots_d[i] = NO_CARD;
            end
            count_d = count_q - 4'd1;
          end
        end
        OP_CLEAR: begin
          slots_d = {MAX_CARDS{NO_CARD}};
          count_d = 4'd0;
        end
        default: ;
      endcase
      if (count_d == 4'd0) cursor_d = 3'd0;
      else if ({1'b0, cursor_d} > count_d - 4'd1) cursor_d = 3'(count_d - 4'd1);
    end

    // Cursor moves see the post-commit hand when they coincide with a commit.
    if ((cur_left ^ cur_right) && (count_d != 4'd0)) begin
      if (cur_left) cursor_d = (cursor_d == 3'd0) ? 3'(count_d - 4'd1) : cursor_d - 3'd1;
      else          cursor_d = ({1'b0, cursor_d} == count_d - 4'd1) ? 3'd0 : cursor_d + 3'd1;
    end

    ready_d = (state_d != CMD_PEND);
  end

  hand_hit_test u_hit (
    .x_cnt   (x_cnt),
    .y_cnt   (y_cnt),
    .count   (count_q),
    .cursor  (cursor_q),
    .hit_c   (hit_c),
    .idx_c   (hit_idx_c),
    .x_pin_c (x_pin_c),
    .y_pin_c (y_pin_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= CMD_IDLE;
      op_q       <= OP_NOP;
      arg_card_q <= NO_CARD;
      arg_idx_q  <= 3'd0;
      slots_q    <= {MAX_CARDS{NO_CARD}};
      count_q    <= 4'd0;
      cursor_q   <= 3'd0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      card       <= NO_CARD;
      card_hit   <= 1'b0;
      x_pin      <= 10'd0;
      y_pin      <= 10'd0;
      x_cnt_d    <= 10'd0;
      y_cnt_d    <= 10'd0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      arg_card_q <= arg_card_d;
      arg_idx_q  <= arg_idx_d;
      slots_q    <= slots_d;
      count_q    <= count_d;
      cursor_q   <= cursor_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
      card       <= hit_c ? slots_q[hit_idx_c] : NO_CARD;
      card_hit   <= hit_c;
      x_pin      <= hit_c ? x_pin_c : 10'd0;
      y_pin      <= hit_c ? y_pin_c : 10'd0;
      x_cnt_d    <= x_cnt;
      y_cnt_d    <= y_cnt;
    end
  end

endmodule

// File: tb/tb_hand_render_scheduler.sv
// Directed bench for hand_render_scheduler: commands, cursor moves and pixel hit tests.
module tb_hand_render_scheduler;
  import uno_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] x_cnt, y_cnt;
  logic       frame_start, cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [5:0] cmd_card;
  logic [2:0] cmd_idx;
  logic       cmd_done, cmd_err, cur_left, cur_right;
  logic [2:0] cursor;
  logic [3:0] hand_count;
  logic [5:0] card;
  logic       card_hit;
  logic [9:0] x_pin, y_pin, x_cnt_d, y_cnt_d;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hand_render_scheduler dut (
    .clk(clk), .rst_n(rst_n), .x_cnt(x_cnt), .y_cnt(y_cnt), .frame_start(frame_start),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_card(cmd_card),
    .cmd_idx(cmd_idx), .cmd_done(cmd_done), .cmd_err(cmd_err), .cur_left(cur_left),
    .cur_right(cur_right), .cursor(cursor), .hand_count(hand_count), .card(card),
    .card_hit(card_hit), .x_pin(x_pin), .y_pin(y_pin), .x_cnt_d(x_cnt_d), .y_cnt_d(y_cnt_d)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command, commit it with a frame_start pulse, and check the handshake.
  task automatic do_cmd(input string tag, input logic [1:0] op, input logic [5:0] cd,
                        input logic [2:0] idx, input logic exp_err, input logic [3:0] exp_count);
    int waited = 0;
    while (cmd_ready !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    chk({tag, "_ready_idle"}, 32'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_card = cd; cmd_idx = idx;
    tick();
    cmd_valid = 1'b0;
    chk({tag, "_ready_pend"}, 32'(cmd_ready), 0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk({tag, "_done"}, 32'(cmd_done), 1);
    chk({tag, "_err"}, 32'(cmd_err), 32'(exp_err));
    chk({tag, "_count"}, 32'(hand_count), 32'(exp_count));
    chk({tag, "_ready_commit"}, 32'(cmd_ready), 1);
    tick();
    chk({tag, "_done_clr"}, 32'(cmd_done), 0);
  endtask

  task automatic pixel(input string tag, input logic [9:0] x, input logic [9:0] y,
                       input logic [5:0] exp_card, input logic exp_hit,
                       input logic [9:0] exp_xp, input logic [9:0] exp_yp);
    x_cnt = x; y_cnt = y;
    tick();
    chk({tag, "_card"}, 32'(card), 32'(exp_card));
    chk({tag, "_hit"}, 32'(card_hit), 32'(exp_hit));
    chk({tag, "_xpin"}, 32'(x_pin), 32'(exp_xp));
    chk({tag, "_ypin"}, 32'(y_pin), 32'(exp_yp));
    chk({tag, "_xd"}, 32'(x_cnt_d), 32'(x));
    chk({tag, "_yd"}, 32'(y_cnt_d), 32'(y));
  endtask

  task automatic move(input logic l, input logic r);
    cur_left = l; cur_right = r;
    tick();
    cur_left = 1'b0; cur_right = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; x_cnt = '0; y_cnt = '0; frame_start = 1'b0; cmd_valid = 1'b0;
    cmd_op = '0; cmd_card = '0; cmd_idx = '0; cur_left = 1'b0; cur_right = 1'b0;
    tick(); tick();
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_done", 32'(cmd_done), 0);
    chk("rst_count", 32'(hand_count), 0);
    chk("rst_cursor", 32'(cursor), 0);
    chk("rst_card", 32'(card), 32'h3F);
    chk("rst_hit", 32'(card_hit), 0);
    rst_n = 1'b1;
    tick();

    // Single ADD, then a pixel on the raised cursor card.
    do_cmd("t1_add", OP_ADD, 6'h05, 3'd0, 1'b0, 4'd1);
    pixel("t1_px", 10'd45, 10'd375, 6'h05, 1'b1, 10'd40, 10'd370);

    // Fill the hand, then overflow.
    for (int k = 1; k < 8; k++) do_cmd("t2_fill", OP_ADD, 6'(5 + k), 3'd0, 1'b0, 4'(k + 1));
    do_cmd("t2_over", OP_ADD, 6'h20, 3'd0, 1'b1, 4'd8);
    pixel("t2_slot7", 10'd535, 10'd385, 6'h0C, 1'b1, 10'd530, 10'd380);
    do_cmd("t2_clear", OP_CLEAR, 6'h00, 3'd0, 1'b0, 4'd0);
    pixel("t2_empty", 10'd45, 10'd385, 6'h3F, 1'b0, 10'd0, 10'd0);

    // REMOVE shifts down and clamps cursor.
    do_cmd("t3_a1", OP_ADD, 6'h01, 3'd0, 1'b0, 4'd1);
    do_cmd("t3_a2", OP_ADD, 6'h02, 3'd0, 1'b0, 4'd2);
    do_cmd("t3_a3", OP_ADD, 6'h03, 3'd0, 1'b0, 4'd3);
    move(1'b0, 1'b1);
    move(1'b0, 1'b1);
    chk("t3_cursor2", 32'(cursor), 2);
    do_cmd("t3_rm0", OP_REMOVE, 6'h00, 3'd0, 1'b0, 4'd2);
    chk("t3_cursor_clamp", 32'(cursor), 1);
    pixel("t3_slot0", 10'd45, 10'd385, 6'h02, 1'b1, 10'd40, 10'd380);
    pixel("t3_slot1", 10'd115, 10'd375, 6'h03, 1'b1, 10'd110, 10'd370);
    pixel("t3_slot2", 10'd185, 10'd385, 6'h3F, 1'b0, 10'd0, 10'd0);
    do_cmd("t3_rm5", OP_REMOVE, 6'h00, 3'd5, 1'b1, 4'd2);
    do_cmd("t3_nop", OP_NOP, 6'h00, 3'd0, 1'b0, 4'd2);

    // Command accepted on a frame_start cycle waits for the next one.
    do_cmd("t4_clear", OP_CLEAR, 6'h00, 3'd0, 1'b0, 4'd0);
    cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_card = 6'h11; frame_start = 1'b1;
    tick();
    cmd_valid = 1'b0; frame_start = 1'b0;
    chk("t4_ready0", 32'(cmd_ready), 0);
    chk("t4_nodone", 32'(cmd_done), 0);
    tick(); tick();
    chk("t4_ready_wait", 32'(cmd_ready), 0);
    chk("t4_count_wait", 32'(hand_count), 0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("t4_done", 32'(cmd_done), 1);
    chk("t4_count", 32'(hand_count), 1);
    tick();

    // Cursor wrapping and ignored moves.
    do_cmd("t5_a2", OP_ADD, 6'h12, 3'd0, 1'b0, 4'd2);
    do_cmd("t5_a3", OP_ADD, 6'h13, 3'd0, 1'b0, 4'd3);
    chk("t5_cursor0", 32'(cursor), 0);
    move(1'b1, 1'b0);
    chk("t5_left_wrap", 32'(cursor), 2);
    move(1'b0, 1'b1);
    chk("t5_right_wrap", 32'(cursor), 0);
    move(1'b0, 1'b1);
    chk("t5_right", 32'(cursor), 1);
    move(1'b1, 1'b1);
    chk("t5_both", 32'(cursor), 1);
    do_cmd("t5_clear", OP_CLEAR, 6'h00, 3'd0, 1'b0, 4'd0);
    chk("t5_clear_cursor", 32'(cursor), 0);
    move(1'b0, 1'b1);
    chk("t5_empty_right", 32'(cursor), 0);
    move(1'b1, 1'b0);
    chk("t5_empty_left", 32'(cursor), 0);

    // Raised-card geometry and rectangle edges.
    do_cmd("t6_a1", OP_ADD, 6'h20, 3'd0, 1'b0, 4'd1);
    pixel("t6_raised", 10'd45, 10'd372, 6'h20, 1'b1, 10'd40, 10'd370);
    do_cmd("t6_a2", OP_ADD, 6'h21, 3'd0, 1'b0, 4'd2);
    move(1'b0, 1'b1);
    chk("t6_cursor1", 32'(cursor), 1);
    pixel("t6_lowered", 10'd45, 10'd372, 6'h3F, 1'b0, 10'd0, 10'd0);
    pixel("t6_top", 10'd45, 10'd380, 6'h20, 1'b1, 10'd40, 10'd380);
    pixel("t6_xedge", 10'd100, 10'd380, 6'h3F, 1'b0, 10'd0, 10'd0);
    pixel("t6_corner", 10'd99, 10'd469, 6'h20, 1'b1, 10'd40, 10'd380);
    pixel("t6_yedge", 10'd45, 10'd470, 6'h3F, 1'b0, 10'd0, 10'd0);
    pixel("t6_s1_top", 10'd110, 10'd370, 6'h21, 1'b1, 10'd110, 10'd370);
    pixel("t6_s1_above", 10'd110, 10'd369, 6'h3F, 1'b0, 10'd0, 10'd0);

    // Reset while a command is pending drops it.
    cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_card = 6'h30;
    tick();
    cmd_valid = 1'b0;
    chk("t7_pend", 32'(cmd_ready), 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t7_ready", 32'(cmd_ready), 1);
    chk("t7_count", 32'(hand_count), 0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("t7_nodone", 32'(cmd_done), 0);
    chk("t7_count_after", 32'(hand_count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
